// File: rtl/seg_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a} and active low.
// Anode patterns are active low: bit 0 is the ones digit and bit 1 is the tenths digit.
package seg_pkg;

    typedef enum logic [1:0] {
        ONES   = 2'd0,
        GAP0   = 2'd1,
        TENTHS = 2'd2,
        GAP1   = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_ONES   = 2'b10;
    localparam logic [1:0] AN_TENTHS = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder.
// All 8 input bits are compared, so any value above 9 shows 'E'.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [7:0] i_digit,
    output logic [6:0] o_seg
);

    // Map the digit value to its active-low segment pattern.
    always_comb begin
        o_seg = SEG_E;
        case (i_digit)
            8'd0:    o_seg = SEG_0;
            8'd1:    o_seg = SEG_1;
            8'd2:    o_seg = SEG_2;
            8'd3:    o_seg = SEG_3;
            8'd4:    o_seg = SEG_4;
            8'd5:    o_seg = SEG_5;
            8'd6:    o_seg = SEG_6;
            8'd7:    o_seg = SEG_7;
            8'd8:    o_seg = SEG_8;
            8'd9:    o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Two-digit time-multiplexed seven-segment driver that displays "X.Y".
// A digit pair is taken through a valid/ready handshake into a one-entry
// pending buffer. The pending pair moves to the display registers only at a
// frame boundary (GAP1 -> ONES), so the display never tears.
// Optional feature: define SEG_DIM_EN to add the brightness port and PWM
// dimming of the active anode.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 500
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] ones_digit,
    input  logic [7:0] tenths_digit,
`ifdef SEG_DIM_EN
    input  logic [3:0] brightness,
`endif
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int unsigned CW = $clog2((REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD);
    localparam logic [CW-1:0] LD_SLOT = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LD_GAP  = CW'(GUARD - 1);

    scan_state_t r_state;
    logic [CW-1:0] r_cnt;

    logic       r_pend_full;
    logic       r_in_ready;
    logic       r_disp_loaded;
    logic [7:0] r_pend_ones;
    logic [7:0] r_pend_tenths;
    logic [7:0] r_disp_ones;
    logic [7:0] r_disp_tenths;

    logic [6:0] r_seg;
    logic       r_dp;
    logic [1:0] r_an;

    logic       w_boundary;
    logic       w_accept;
    logic [7:0] w_digit;
    logic [6:0] w_seg;
    logic       w_an_on;

    assign w_boundary = (r_state == GAP1) && (r_cnt == '0);
    assign w_accept   = in_valid && r_in_ready;
    assign w_digit    = (r_state == TENTHS) ? r_disp_tenths : r_disp_ones;

    assign in_ready = r_in_ready;
    assign seg      = r_seg;
    assign dp       = r_dp;
    assign an       = r_an;

    seg7_decode u_decode (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

`ifdef SEG_DIM_EN
    logic [3:0] r_pwm_cnt;

    // Free-running PWM phase counter for anode dimming.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_an_on = (brightness == 4'hF) || (r_pwm_cnt < brightness);
`else
    assign w_an_on = 1'b1;
`endif

    // Scan sequencer: one down-counter, reloaded on every state change.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ONES;
            r_cnt   <= LD_SLOT;
        end else if (r_cnt == '0) begin
            case (r_state)
                ONES:    begin r_state <= GAP0;   r_cnt <= LD_GAP;  end
                GAP0:    begin r_state <= TENTHS; r_cnt <= LD_SLOT; end
                TENTHS:  begin r_state <= GAP1;   r_cnt <= LD_GAP;  end
                default: begin r_state <= ONES;   r_cnt <= LD_SLOT; end
            endcase
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Handshake capture into the pending buffer and hand-off at the frame boundary.
    // A capture needs pending to be empty and a hand-off needs it full, so the two never coincide.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend_full   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_disp_loaded <= 1'b0;
            r_pend_ones   <= '0;
            r_pend_tenths <= '0;
            r_disp_ones   <= '0;
            r_disp_tenths <= '0;
        end else if (w_accept) begin
            r_pend_ones   <= ones_digit;
            r_pend_tenths <= tenths_digit;
            r_pend_full   <= 1'b1;
            r_in_ready    <= 1'b0;
        end else if (w_boundary && r_pend_full) begin
            r_disp_ones   <= r_pend_ones;
            r_disp_tenths <= r_pend_tenths;
            r_disp_loaded <= 1'b1;
            r_pend_full   <= 1'b0;
            r_in_ready    <= 1'b1;
        end
    end

    // Registered display outputs. They follow the scan state one cycle later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (!r_disp_loaded) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            case (r_state)
                ONES: begin
                    r_an  <= w_an_on ? AN_ONES : AN_OFF;
                    r_seg <= w_seg;
                    r_dp  <= 1'b0;
                end
                TENTHS: begin
                    r_an  <= w_an_on ? AN_TENTHS : AN_OFF;
                    r_seg <= w_seg;
                    r_dp  <= 1'b1;
                end
                default: begin
                    r_an  <= AN_OFF;
                    r_seg <= SEG_BLANK;
                    r_dp  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed testbench for seg_display_scan with REFRESH_DIV=4 and GUARD=1.
// The dimming checks are compiled in only when SEG_DIM_EN is defined.
module tb_seg_display_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SB = 7'h7F;

    logic       clock = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ones_digit;
    logic [7:0] tenths_digit;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
`ifdef SEG_DIM_EN
    logic [3:0] brightness;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    seg_display_scan #(
        .REFRESH_DIV (4),
        .GUARD       (1)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ones_digit   (ones_digit),
        .tenths_digit (tenths_digit),
`ifdef SEG_DIM_EN
        .brightness   (brightness),
`endif
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e);
        chk({tag, "_an"},  32'(an),  32'(an_e));
        chk({tag, "_seg"}, 32'(seg), 32'(seg_e));
        chk({tag, "_dp"},  32'(dp),  32'(dp_e));
    endtask

    // Offer one pair, wait for ready (bounded), and complete the transfer.
    task automatic send(input string tag, input logic [7:0] o, input logic [7:0] t);
        int unsigned i;
        in_valid     = 1'b1;
        ones_digit   = o;
        tenths_digit = t;
        i = 0;
        while (!in_ready && i < 30) begin
            tick();
            i++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until the ones slot shows the given pattern.
    task automatic wait_show(input string tag, input logic [6:0] seg_e, input int unsigned bound);
        int unsigned i;
        i = 0;
        while (!(an == 2'b10 && seg == seg_e) && i < bound) begin
            tick();
            i++;
        end
        chk({tag, "_show"}, 32'({an, seg}), 32'({2'b10, seg_e}));
    endtask

    // Called on the first ones-slot cycle. Checks one whole frame and stops on the trailing blank cycle.
    task automatic check_frame(input string tag, input logic [6:0] so, input logic [6:0] st);
        for (int unsigned k = 0; k < 4; k++) begin
            check_out({tag, "_ones"}, 2'b10, so, 1'b0);
            tick();
        end
        check_out({tag, "_gap0"}, 2'b11, SB, 1'b1);
        tick();
        for (int unsigned k = 0; k < 4; k++) begin
            check_out({tag, "_tenths"}, 2'b01, st, 1'b1);
            tick();
        end
        check_out({tag, "_gap1"}, 2'b11, SB, 1'b1);
    endtask

`ifdef SEG_DIM_EN
    // Count slot cycles and lit-anode cycles over one 80-cycle period (lcm of frame 10 and pwm 16).
    task automatic duty(input string tag, input logic [3:0] b, input int unsigned lit_e);
        int unsigned lit;
        int unsigned slot;
        brightness = b;
        tick();
        lit  = 0;
        slot = 0;
        for (int unsigned k = 0; k < 80; k++) begin
            if (seg != SB) slot++;
            if (an != 2'b11) lit++;
            tick();
        end
        chk({tag, "_slot"}, slot, 32'd64);
        chk({tag, "_lit"},  lit,  lit_e);
    endtask
`endif

    initial begin
        int unsigned i;
        resetn       = 1'b0;
        in_valid     = 1'b0;
        ones_digit   = '0;
        tenths_digit = '0;
`ifdef SEG_DIM_EN
        brightness   = 4'hF;
`endif

        // Reset state
        #12;
        check_out("rst", 2'b11, SB, 1'b1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        for (int unsigned k = 0; k < 25; k++) begin
            tick();
            chk("idle_an", 32'(an), 32'(2'b11));
        end
        chk("idle_seg", 32'(seg), 32'(SB));

        // Single pair 3.7
        send("p37", 8'd3, 8'd7);
        chk("p37_busy", 32'(in_ready), 32'd0);
        wait_show("p37", S3, 11);
        check_frame("p37", S3, S7);

        // Back-to-back pairs 1.2 then 4.5, with valid held high
        in_valid     = 1'b1;
        ones_digit   = 8'd1;
        tenths_digit = 8'd2;
        i = 0;
        while (!in_ready && i < 30) begin
            tick();
            i++;
        end
        chk("b2b_ready1", 32'(in_ready), 32'd1);
        tick();
        ones_digit   = 8'd4;
        tenths_digit = 8'd5;
        chk("b2b_holdoff", 32'(in_ready), 32'd0);
        tick();
        chk("b2b_holdoff2", 32'(in_ready), 32'd0);
        wait_show("b2b12", S1, 11);
        in_valid = 1'b0;
        chk("b2b_pend2", 32'(in_ready), 32'd0);
        check_frame("b2b12", S1, S2);
        tick();
        wait_show("b2b45", S4, 1);
        check_frame("b2b45", S4, S5);
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);

        // Out-of-range values show 'E' in both slots
        send("oor", 8'd255, 8'd12);
        wait_show("oor", SE, 11);
        check_frame("oor", SE, SE);

        // Asynchronous reset in the middle of the tenths slot
        i = 0;
        while (an != 2'b01 && i < 20) begin
            tick();
            i++;
        end
        chk("mid_tenths", 32'(an), 32'(2'b01));
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_out("async_rst", 2'b11, SB, 1'b1);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        @(negedge clock);
        resetn = 1'b1;
        for (int unsigned k = 0; k < 25; k++) begin
            tick();
            chk("post_rst_an", 32'(an), 32'(2'b11));
        end

        // New pair after reset: 0.9
        send("p09", 8'd0, 8'd9);
        wait_show("p09", S0, 11);
        check_frame("p09", S0, S9);

`ifdef SEG_DIM_EN
        duty("dim0",  4'd0,  32'd0);
        duty("dim8",  4'd8,  32'd32);
        duty("dim15", 4'd15, 32'd64);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
